// File: rtl/seg7_scan_rdr.sv
// -----------------------------------------------------------------------------
// seg7_scan_rdr
//
// Snoops a time-multiplexed seven-segment display bus and rebuilds the BCD
// value shown on each digit. It undoes the BCD-to-seven-segment decoder. A
// digit is captured only after its {dig_en, seg} pattern has been seen
// unchanged for STABLE consecutive clocks. Undecodable segment patterns are
// flagged per digit. A one-cycle frame strobe marks the point where every
// digit has been refreshed.
//
// Parameters
//   NDIG    number of multiplexed digits (>= 1)
//   STABLE  identical synchronised samples required before capture (>= 2)
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   seg      in   segment lines, active high, seg[0]=A .. seg[6]=G (async)
//   dig_en   in   digit enables, active high, expected one-hot (async)
//   bcd      out  captured digits, digit i at bcd[4i+3:4i]
//                 (4'hE = blank, 4'hF = illegal or never captured)
//   err      out  err[i]=1 when digit i's last capture was illegal
//   frm_vld  out  one-cycle pulse once every digit has been captured
// -----------------------------------------------------------------------------
module seg7_scan_rdr #(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg,
    input  logic [NDIG-1:0]   dig_en,
    output logic [4*NDIG-1:0] bcd,
    output logic [NDIG-1:0]   err,
    output logic              frm_vld
);

    localparam int SW = NDIG + 7;
    localparam int CW = $clog2(STABLE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);

    // Returns {err, nibble} for a raw segment pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h3F:   r = 5'h00;
            7'h06:   r = 5'h01;
            7'h5B:   r = 5'h02;
            7'h4F:   r = 5'h03;
            7'h66:   r = 5'h04;
            7'h6D:   r = 5'h05;
            7'h7D:   r = 5'h06;
            7'h07:   r = 5'h07;
            7'h7F:   r = 5'h08;
            7'h6F:   r = 5'h09;
            7'h00:   r = 5'h0E;
            default: r = 5'h1F;
        endcase
        return r;
    endfunction

    logic [SW-1:0]     s1_q, s1_d;
    logic [SW-1:0]     s2_q, s2_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NDIG-1:0]   seen_q, seen_d;
    logic [4*NDIG-1:0] bcd_q, bcd_d;
    logic [NDIG-1:0]   err_q, err_d;
    logic              frm_pend_q, frm_pend_d;
    logic              frm_vld_q, frm_vld_d;

    logic [NDIG-1:0]   new_en;
    logic [6:0]        new_seg;
    logic              new_onehot;
    logic              capture;
    logic [4:0]        dec;
    logic [NDIG-1:0]   seen_nxt;

    always_comb begin
        s1_d = {dig_en, seg};
        s2_d = s1_q;

        // s1_q is the value s2 takes on this edge, so it drives all decisions.
        new_en     = s1_q[SW-1:7];
        new_seg    = s1_q[6:0];
        new_onehot = (new_en != '0) && ((new_en & (new_en - NDIG'(1))) == '0);

        // Blank gaps and ghosted (multi-hot) enables park the counter at 0.
        if (!new_onehot) begin
            cnt_d = '0;
        end else if (s1_q != s2_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Capture only on the transition into STABLE, not while saturated.
        capture = new_onehot && (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
        dec     = seg_decode(new_seg);

        bcd_d      = bcd_q;
        err_d      = err_q;
        seen_d     = seen_q;
        seen_nxt   = seen_q | new_en;
        frm_pend_d = 1'b0;
        frm_vld_d  = frm_pend_q;

        if (capture) begin
            for (int i = 0; i < NDIG; i++) begin
                if (new_en[i]) begin
                    bcd_d[4*i +: 4] = dec[3:0];
                    err_d[i]        = dec[4];
                end
            end
            // Completing capture clears seen now; the strobe is delayed by
            // one extra stage so it lands the cycle after bcd updates.
            if (&seen_nxt) begin
                seen_d     = '0;
                frm_pend_d = 1'b1;
            end else begin
                seen_d = seen_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            cnt_q      <= '0;
            seen_q     <= '0;
            bcd_q      <= '1;
            err_q      <= '0;
            frm_pend_q <= 1'b0;
            frm_vld_q  <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            bcd_q      <= bcd_d;
            err_q      <= err_d;
            frm_pend_q <= frm_pend_d;
            frm_vld_q  <= frm_vld_d;
        end
    end

    assign bcd     = bcd_q;
    assign err     = err_q;
    assign frm_vld = frm_vld_q;

endmodule

// File: tb/tb_seg7_scan_rdr.sv
module tb_seg7_scan_rdr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic [15:0] bcd;
    logic [3:0]  err;
    logic        frm_vld;

    int checks  = 0;
    int errors  = 0;
    int frm_cnt = 0;

    logic [6:0] pats [4] = '{7'h06, 7'h5B, 7'h4F, 7'h66};

    seg7_scan_rdr #(.NDIG(4), .STABLE(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg     (seg),
        .dig_en  (dig_en),
        .bcd     (bcd),
        .err     (err),
        .frm_vld (frm_vld)
    );

    always #5 clk = ~clk;

    // Counts cycles in which frm_vld is high at a rising edge.
    always @(posedge clk) begin
        if (frm_vld === 1'b1) frm_cnt <= frm_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held while a valid pattern is already on the bus
        rst_n  = 1'b0;
        dig_en = 4'b0001;
        seg    = 7'h4F;
        tick(3);
        chk("rst_bcd", 32'(bcd), 32'hFFFF);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_frm", 32'(frm_vld), 32'h0);

        // Release; pattern held -> captured on the 4th edge after release
        rst_n = 1'b1;
        tick(3);
        chk("d0_before_stable", 32'(bcd), 32'hFFFF);
        tick(1);
        chk("d0_capture", 32'(bcd), 32'hFFF3);
        chk("d0_err", 32'(err), 32'h0);
        chk("d0_no_frm", 32'(frm_vld), 32'h0);
        tick(3);
        chk("d0_hold", 32'(bcd), 32'hFFF3);
        chk("d0_no_frm_later", 32'(frm_cnt), 32'd0);
        dig_en = 4'b0000; seg = 7'h00;
        tick(2);

        // Short dwell of 2 cycles: no capture
        dig_en = 4'b0010; seg = 7'h6D;
        tick(2);
        dig_en = 4'b0000; seg = 7'h00;
        tick(4);
        chk("short_dwell", 32'(bcd), 32'hFFF3);

        // Dwell of exactly 3 cycles: captured
        dig_en = 4'b0010; seg = 7'h6D;
        tick(3);
        dig_en = 4'b0000; seg = 7'h00;
        tick(1);
        chk("exact_dwell", 32'(bcd), 32'hFF53);
        tick(2);

        // Reset mid-dwell discards captured digits and the partial count
        dig_en = 4'b0100; seg = 7'h7F;
        tick(2);
        rst_n = 1'b0;
        #2;
        chk("rst_async_bcd", 32'(bcd), 32'hFFFF);
        tick(1);
        dig_en = 4'b0000; seg = 7'h00;
        rst_n  = 1'b1;
        tick(4);
        chk("rst_mid_bcd", 32'(bcd), 32'hFFFF);

        // Two full scans of 1,2,3,4 with a blank cycle between digits
        for (int scan = 0; scan < 2; scan++) begin
            for (int d = 0; d < 4; d++) begin
                dig_en = 4'(1 << d);
                seg    = pats[d];
                tick(4);
                chk("frame_nibble", 32'(bcd[4*d +: 4]), 32'(d + 1));
                chk("frame_frm_at_cap", 32'(frm_vld), 32'h0);
                tick(1);
                chk("frame_frm_next", 32'(frm_vld), 32'((d == 3) ? 1 : 0));
                dig_en = 4'b0000; seg = 7'h00;
                tick(1);
                chk("frame_frm_drop", 32'(frm_vld), 32'h0);
            end
            chk("frame_bcd", 32'(bcd), 32'h4321);
            chk("frame_pulses", 32'(frm_cnt), 32'(scan + 1));
        end

        // Illegal pattern on digit 2, then blank on the same digit
        dig_en = 4'b0100; seg = 7'h01;
        tick(4);
        chk("illegal_bcd", 32'(bcd), 32'h4F21);
        chk("illegal_err", 32'(err), 32'h4);
        seg = 7'h00;
        tick(3);
        chk("blank_pending", 32'(bcd), 32'h4F21);
        tick(1);
        chk("blank_bcd", 32'(bcd), 32'h4E21);
        chk("blank_err", 32'(err), 32'h0);
        dig_en = 4'b0000;
        tick(2);

        // Ghosted enables never capture
        dig_en = 4'b0101; seg = 7'h7F;
        tick(10);
        chk("ghost_bcd", 32'(bcd), 32'h4E21);
        chk("ghost_cnt", 32'(dut.cnt_q), 32'h0);
        chk("ghost_err", 32'(err), 32'h0);
        dig_en = 4'b0100;
        tick(3);
        chk("deghost_pending", 32'(bcd), 32'h4E21);
        tick(1);
        chk("deghost_bcd", 32'(bcd), 32'h4821);
        chk("final_pulses", 32'(frm_cnt), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
